// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  localparam int DATA_W      = 16;
  localparam int MAX_LATENCY = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port RAM, DEPTH words of DATA_W bits, registered read.
// Latency: read data valid one cycle after an enabled access.
// Backpressure: none; rdata holds its value while en is low.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled cycle; read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the 16-bit CPU: one outstanding request, LATENCY wait states.
// Latency: accept at edge N -> rsp_valid after edge N+LATENCY+1 (last wait cycle is the RAM access).
// Backpressure: req_ready low outside IDLE; response held stable until rsp_valid&rsp_ready.
// Optional: define DMEM_ALIGN_CHECK_EN to flag odd byte addresses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Out-of-range LATENCY values saturate at the supported maximum.
  localparam logic [2:0]  LAT_CNT   = 3'((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
  localparam logic [15:0] DEPTH_LIM = 16'((DEPTH > 32768) ? 32768 : DEPTH);

  state_t state, state_nxt;

  logic [2:0]        cnt;
  logic              we_q;
  logic [14:0]       idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              mis_q;
`endif

  logic              accept;
  logic              commit;
  logic              hshake;
  logic              bad;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign accept = req_valid && (state == IDLE);
  // The final WAIT cycle performs the RAM access, so the response data is
  // registered exactly on the edge that enters RESP.
  assign commit = (state == WAIT) && (cnt == 3'd0);
  assign hshake = (state == RESP) && rsp_ready;

  // Decide whether the latched request is illegal (range, optionally alignment).
  always_comb begin
    bad = ({1'b0, idx_q} >= DEPTH_LIM);
`ifdef DMEM_ALIGN_CHECK_EN
    if (mis_q) begin
      bad = 1'b1;
    end
`endif
  end

  // The RAM has no reset, so a reset edge must never carry a commit into it.
  assign ram_en = commit && !bad && rst_n;
  assign ram_we = ram_en && we_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait-state counter and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt     <= LAT_CNT;
        we_q    <= req_we;
        idx_q   <= req_addr[15:1];
        wdata_q <= req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
        mis_q   <= req_addr[0];
`endif
      end else if ((state == WAIT) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      if (commit) begin
        err_q <= bad;
      end else if (hshake) begin
        err_q <= 1'b0;
      end
    end
  end

  // Outputs decoded from state; load data gated so stores, errors and idle read as zero.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err_q;
    rsp_rdata = '0;
    if ((state == RESP) && !we_q && !err_q) begin
      rsp_rdata = ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 1, 4, 0) sharing clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;

  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  // Full transaction on instance i, starting and ending at a falling edge.
  // Inputs are scrambled right after acceptance to show they are not resampled.
  task automatic txn(input int i, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, output int lat,
                     output logic [15:0] rdata, output logic err);
    int guard;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    guard = 0;
    while (!req_ready[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    req_we[i]    = ~we;
    req_addr[i]  = 16'hFFFE;
    req_wdata[i] = ~wdata;
    lat = 0;
    while (!rsp_valid[i] && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[i];
    err   = rsp_err[i];
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (req_ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready[%0d]: got %b want 1", i, req_ready[i]); end
      n_checks++;
      if (rsp_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", i, rsp_valid[i]); end
      n_checks++;
      if (rsp_rdata[i] !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_rdata[%0d]: got %h want 0000", i, rsp_rdata[i]); end
      n_checks++;
      if (rsp_err[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err[%0d]: got %b want 0", i, rsp_err[i]); end
    end
  endtask

  task automatic test_store_load;
    int lat; logic [15:0] rd; logic er;
    txn(0, 1'b1, 16'h0004, 16'h00AB, lat, rd, er);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d want 2", lat); end
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL store_rdata: got %h want 0000", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b want 0", er); end
    txn(0, 1'b0, 16'h0004, 16'h0000, lat, rd, er);
    n_checks++;
    if (rd !== 16'h00AB) begin n_fail++; $display("FAIL load_after_store: got %h want 00ab", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL load_after_store_err: got %b want 0", er); end
  endtask

  task automatic test_backpressure;
    int lat;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0002; req_wdata[0] = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    // Keep req_valid high with a different request; it must wait for the handshake.
    req_addr[0] = 16'h0000;
    lat = 0;
    while (!rsp_valid[0] && lat < 50) begin @(posedge clk); @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", k, rsp_valid[0]); end
      n_checks++;
      if (rsp_rdata[0] !== 16'h0007) begin n_fail++; $display("FAIL bp_rdata_hold[%0d]: got %h want 0007", k, rsp_rdata[0]); end
      n_checks++;
      if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", k, req_ready[0]); end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    n_checks++;
    if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_in_handshake: got %b want 0", req_ready[0]); end
    @(posedge clk);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    n_checks++;
    if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after: got %b want 0", rsp_valid[0]); end
    n_checks++;
    if (rsp_rdata[0] !== 16'h0000) begin n_fail++; $display("FAIL bp_rdata_after: got %h want 0000", rsp_rdata[0]); end
    n_checks++;
    if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b want 1", req_ready[0]); end
    // The held request is accepted now and reads word 0.
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    lat = 0;
    while (!rsp_valid[0] && lat < 50) begin @(posedge clk); @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 2", lat); end
    n_checks++;
    if (rsp_rdata[0] !== 16'h0005) begin n_fail++; $display("FAIL bp_second_rdata: got %h want 0005", rsp_rdata[0]); end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_out_of_range;
    int lat; logic [15:0] rd; logic er;
    txn(0, 1'b1, 16'h0800, 16'h5555, lat, rd, er);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b want 1", er); end
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL oor_store_rdata: got %h want 0000", rd); end
    // Index 1024 would alias word 0 in a 10-bit RAM; it must be untouched.
    txn(0, 1'b0, 16'h0000, 16'h0000, lat, rd, er);
    n_checks++;
    if (rd !== 16'h0005) begin n_fail++; $display("FAIL oor_no_write: got %h want 0005", rd); end
    txn(0, 1'b0, 16'h07FE, 16'h0000, lat, rd, er);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b want 0", er); end
    txn(0, 1'b0, 16'hFFFE, 16'h0000, lat, rd, er);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL top_addr_err: got %b want 1", er); end
  endtask

  task automatic test_reset_mid_wait;
    int lat; logic [15:0] rd; logic er;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 16'h0010; req_wdata[1] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL mid_wait_busy: got %b want 0", req_ready[1]); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL mid_wait_idle: got %b want 1", req_ready[1]); end
    n_checks++;
    if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL mid_wait_valid: got %b want 0", rsp_valid[1]); end
    txn(1, 1'b0, 16'h0010, 16'h0000, lat, rd, er);
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL mid_wait_dropped: got %h want 0000", rd); end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL lat4_latency: got %0d want 5", lat); end
  endtask

  task automatic test_latency0;
    int lat; logic [15:0] rd; logic er;
    txn(2, 1'b0, 16'h0000, 16'h0000, lat, rd, er);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL lat0_latency: got %0d want 1", lat); end
    n_checks++;
    if (rd !== 16'h0005) begin n_fail++; $display("FAIL lat0_rdata: got %h want 0005", rd); end
  endtask

  task automatic test_alignment;
    int lat; logic [15:0] rd; logic er;
    txn(2, 1'b0, 16'h0003, 16'h0000, lat, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_err: got %b want 1", er); end
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL misaligned_rdata: got %h want 0000", rd); end
`else
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL odd_addr_err: got %b want 0", er); end
    n_checks++;
    if (rd !== 16'h0007) begin n_fail++; $display("FAIL odd_addr_rdata: got %h want 0007", rd); end
`endif
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL odd_addr_latency: got %0d want 1", lat); end
  endtask

  // With req_valid and rsp_ready held high, LATENCY=0 accepts every 3 cycles.
  task automatic test_back_to_back;
    int accepts;
    accepts = 0;
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 16'h0000;
    rsp_ready[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (req_ready[2]) accepts++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    rsp_ready[2] = 1'b0;
    n_checks++;
    if (accepts !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", accepts); end
    n_checks++;
    if (req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_end_idle: got %b want 1", req_ready[2]); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   rsp_ready[i] = 1'b0;
    end
    for (int k = 0; k < 1024; k++) begin
      dut_l1.u_array.mem[k] = 16'h0000;
      dut_l4.u_array.mem[k] = 16'h0000;
      dut_l0.u_array.mem[k] = 16'h0000;
    end
    dut_l1.u_array.mem[0] = 16'h0005; dut_l1.u_array.mem[1] = 16'h0007;
    dut_l4.u_array.mem[0] = 16'h0005; dut_l4.u_array.mem[1] = 16'h0007;
    dut_l0.u_array.mem[0] = 16'h0005; dut_l0.u_array.mem[1] = 16'h0007;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_wait();
    test_latency0();
    test_alignment();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
